// File: rtl/bcd_countdown_mmss.sv
// Loadable BCD mm:ss down-counter with done pulse, expired level and load_err pulse.
// Optional macro BCD_COUNTDOWN_AUTO_RELOAD_EN: reload the last accepted load value on reaching 00:00.
module bcd_countdown_mmss #(
  parameter int unsigned TICK_DIV = 50000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] ld_min_hi,
  input  logic [3:0] ld_min_lo,
  input  logic [3:0] ld_sec_hi,
  input  logic [3:0] ld_sec_lo,
  input  logic       start,
  input  logic       pause,
  output logic [3:0] min_hi,
  output logic [3:0] min_lo,
  output logic [3:0] sec_hi,
  output logic [3:0] sec_lo,
  output logic       running,
  output logic       done,
  output logic       expired,
  output logic       load_err
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSED, EXPIRED} state_e;

  state_e        state_q, state_d;
  logic [15:0]   val_q, val_d;
  logic [PW-1:0] pre_q, pre_d;
  logic          done_q, done_d;
  logic          lerr_q, lerr_d;

  logic [15:0]   ld_val, dec_val;
  logic          ld_valid, is_zero, is_one, tick;
  logic          b0, b1, b2;

`ifdef BCD_COUNTDOWN_AUTO_RELOAD_EN
  logic [15:0]   rld_q, rld_d;
`endif

  assign ld_val   = {ld_min_hi, ld_min_lo, ld_sec_hi, ld_sec_lo};
  assign ld_valid = (ld_min_hi <= 4'd5) && (ld_min_lo <= 4'd9) &&
                    (ld_sec_hi <= 4'd5) && (ld_sec_lo <= 4'd9);
  assign is_zero  = (val_q == 16'h0000);
  assign is_one   = (val_q == 16'h0001);
  assign tick     = (pre_q == PRE_MAX);

  // Ripple borrow from seconds units up to minutes tens.
  always_comb begin
    b0 = (val_q[3:0] == 4'd0);
    b1 = b0 && (val_q[7:4] == 4'd0);
    b2 = b1 && (val_q[11:8] == 4'd0);
    dec_val[3:0]   = b0 ? 4'd9 : val_q[3:0] - 4'd1;
    dec_val[7:4]   = !b0 ? val_q[7:4]   : (b1 ? 4'd5 : val_q[7:4] - 4'd1);
    dec_val[11:8]  = !b1 ? val_q[11:8]  : (b2 ? 4'd9 : val_q[11:8] - 4'd1);
    dec_val[15:12] = !b2 ? val_q[15:12] : val_q[15:12] - 4'd1;
  end

  always_comb begin
    state_d = state_q;
    val_d   = val_q;
    pre_d   = pre_q;
    done_d  = 1'b0;
    lerr_d  = 1'b0;
`ifdef BCD_COUNTDOWN_AUTO_RELOAD_EN
    rld_d   = rld_q;
`endif
    // A load outside RUN owns the cycle even when rejected, so a paired start is dropped.
    if (load && state_q != RUN) begin
      if (ld_valid) begin
        val_d   = ld_val;
        pre_d   = '0;
        state_d = IDLE;
`ifdef BCD_COUNTDOWN_AUTO_RELOAD_EN
        rld_d   = ld_val;
`endif
      end else begin
        lerr_d = 1'b1;
      end
    end else if (pause && state_q == RUN) begin
      state_d = PAUSED;
    end else if (start && (state_q == IDLE || state_q == PAUSED) && !is_zero) begin
      state_d = RUN;
      if (state_q == IDLE) pre_d = '0;
    end else if (state_q == RUN) begin
      if (tick) begin
        pre_d = '0;
        val_d = dec_val;
        if (is_one) begin
          done_d = 1'b1;
`ifdef BCD_COUNTDOWN_AUTO_RELOAD_EN
          if (rld_q != 16'h0000) val_d = rld_q;
          else state_d = EXPIRED;
`else
          state_d = EXPIRED;
`endif
        end
      end else begin
        pre_d = pre_q + PW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      val_q   <= '0;
      pre_q   <= '0;
      done_q  <= 1'b0;
      lerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      val_q   <= val_d;
      pre_q   <= pre_d;
      done_q  <= done_d;
      lerr_q  <= lerr_d;
    end
  end

`ifdef BCD_COUNTDOWN_AUTO_RELOAD_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rld_q <= '0;
    else        rld_q <= rld_d;
  end
`endif

  assign min_hi   = val_q[15:12];
  assign min_lo   = val_q[11:8];
  assign sec_hi   = val_q[7:4];
  assign sec_lo   = val_q[3:0];
  assign running  = (state_q == RUN);
  assign expired  = (state_q == EXPIRED);
  assign done     = done_q;
  assign load_err = lerr_q;

endmodule

// File: tb/tb_bcd_countdown_mmss.sv
// Scoreboard bench: a seconds-based reference model predicts every cycle's outputs; a monitor compares.
module tb_bcd_countdown_mmss;

  localparam int TD = 4;
`ifdef BCD_COUNTDOWN_AUTO_RELOAD_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_EXP = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       load = 1'b0, start = 1'b0, pause = 1'b0;
  logic [3:0] ld_min_hi = '0, ld_min_lo = '0, ld_sec_hi = '0, ld_sec_lo = '0;
  logic [3:0] min_hi, min_lo, sec_hi, sec_lo;
  logic       running, done, expired, load_err;

  bcd_countdown_mmss #(.TICK_DIV(TD)) dut (
    .clk(clk), .reset(reset), .load(load),
    .ld_min_hi(ld_min_hi), .ld_min_lo(ld_min_lo), .ld_sec_hi(ld_sec_hi), .ld_sec_lo(ld_sec_lo),
    .start(start), .pause(pause),
    .min_hi(min_hi), .min_lo(min_lo), .sec_hi(sec_hi), .sec_lo(sec_lo),
    .running(running), .done(done), .expired(expired), .load_err(load_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [19:0] exp_q[$];
  string       tag_q[$];

  // Reference model: remaining time in whole seconds plus cycles into the current second.
  int m_mode = M_IDLE, m_secs = 0, m_phase = 0, m_reload = 0;
  bit m_done = 0, m_lerr = 0;

  function automatic logic [19:0] model_outputs();
    logic [3:0] a, b, c, d;
    a = 4'(m_secs / 600);
    b = 4'((m_secs / 60) % 10);
    c = 4'((m_secs % 60) / 10);
    d = 4'(m_secs % 10);
    return {a, b, c, d, m_mode == M_RUN, m_done, m_mode == M_EXP, m_lerr};
  endfunction

  task automatic model_step(input bit rst_n, input bit ld, input bit st, input bit pa,
                            input logic [15:0] v);
    int a, b, c, d;
    a = int'(v[15:12]); b = int'(v[11:8]); c = int'(v[7:4]); d = int'(v[3:0]);
    m_done = 0;
    m_lerr = 0;
    if (!rst_n) begin
      m_mode = M_IDLE; m_secs = 0; m_phase = 0; m_reload = 0;
    end else if (ld && m_mode != M_RUN) begin
      if (a <= 5 && b <= 9 && c <= 5 && d <= 9) begin
        m_secs = (a * 10 + b) * 60 + c * 10 + d;
        m_reload = m_secs;
        m_phase = 0;
        m_mode = M_IDLE;
      end else begin
        m_lerr = 1;
      end
    end else if (pa && m_mode == M_RUN) begin
      m_mode = M_PAUSED;
    end else if (st && (m_mode == M_IDLE || m_mode == M_PAUSED) && m_secs != 0) begin
      if (m_mode == M_IDLE) m_phase = 0;
      m_mode = M_RUN;
    end else if (m_mode == M_RUN) begin
      m_phase++;
      if (m_phase == TD) begin
        m_phase = 0;
        m_secs--;
        if (m_secs == 0) begin
          m_done = 1;
          if (AUTO && m_reload != 0) m_secs = m_reload;
          else m_mode = M_EXP;
        end
      end
    end
  endtask

  task automatic drive(input bit rst_n, input bit ld, input bit st, input bit pa,
                       input logic [15:0] v, input string tag);
    @(negedge clk);
    reset = rst_n; load = ld; start = st; pause = pa;
    {ld_min_hi, ld_min_lo, ld_sec_hi, ld_sec_lo} = v;
    model_step(rst_n, ld, st, pa, v);
    exp_q.push_back(model_outputs());
    tag_q.push_back(tag);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, tag);
  endtask

  // Monitor: registered outputs are sampled just after each rising edge.
  initial begin
    logic [19:0] got, want;
    string t;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        want = exp_q.pop_front();
        t = tag_q.pop_front();
        got = {min_hi, min_lo, sec_hi, sec_lo, running, done, expired, load_err};
        checks++;
        if (got !== want) begin
          errors++;
          $display("FAIL %s: got %0h:%0h:%0h:%0h run=%b done=%b exp=%b lerr=%b want %0h:%0h:%0h:%0h run=%b done=%b exp=%b lerr=%b",
                   t, got[19:16], got[15:12], got[11:8], got[7:4], got[3], got[2], got[1], got[0],
                   want[19:16], want[15:12], want[11:8], want[7:4], want[3], want[2], want[1], want[0]);
        end
      end
    end
  end

  initial begin
    int r;
    logic [15:0] v;

    drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, "reset");
    drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, "reset");
    idle(1, "post_reset");

    drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0100, "load_0100");
    drive(1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, "start_0100");
    idle(9, "count_0100");

    drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0002, "load_0002");
    drive(1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, "start_0002");
    idle(9, "expire_0002");
    drive(1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, "start_in_expired");
    idle(2, "hold_expired");

    drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h1000, "load_1000");
    drive(1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, "start_1000");
    idle(2, "run_1000");
    drive(1'b1, 1'b0, 1'b1, 1'b1, 16'h0000, "pause_start");
    idle(3, "paused");
    drive(1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, "resume");
    idle(6, "borrow_0959");

    drive(1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, "pause2");
    drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0670, "bad_load");
    idle(1, "after_bad_load");
    drive(1'b1, 1'b1, 1'b1, 1'b0, 16'h0F00, "bad_load_start");
    drive(1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, "resume2");
    drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0300, "load_in_run");
    idle(2, "run_after_load");
    drive(1'b1, 1'b1, 1'b0, 1'b1, 16'h0300, "load_pause_run");
    drive(1'b1, 1'b1, 1'b1, 1'b0, 16'h0005, "load_start_idle");
    idle(2, "idle_0005");

    drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0001, "load_0001");
    drive(1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, "start_0001");
    idle(10, "reload_0001");
    drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, "load_0000");
    drive(1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, "start_zero");
    drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0130, "load_0130");
    drive(1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, "start_0130");
    idle(5, "run_0130");

    // Asynchronous reset mid-RUN must clear outputs before any clock edge.
    @(negedge clk);
    reset = 1'b0;
    model_step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    #1;
    checks++;
    if ({min_hi, min_lo, sec_hi, sec_lo, running, done, expired, load_err} !== 20'h0) begin
      errors++;
      $display("FAIL async_reset: got %0h%0h:%0h%0h run=%b want 00:00 run=0",
               min_hi, min_lo, sec_hi, sec_lo, running);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, "reset_hold");
    idle(2, "after_reset");

    for (int n = 0; n < 2500; n++) begin
      r = $urandom_range(0, 199);
      v[15:12] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'd0;
      v[11:8]  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 11)) : 4'd0;
      v[7:4]   = 4'($urandom_range(0, 6));
      v[3:0]   = 4'($urandom_range(0, 10));
      if (r == 0)       drive(1'b0, 1'b0, 1'b0, 1'b0, v, "rand_reset");
      else if (r < 8)   drive(1'b1, 1'b1, r[0], r[1], v, "rand_load");
      else if (r < 30)  drive(1'b1, 1'b0, 1'b1, r[0], v, "rand_start");
      else if (r < 36)  drive(1'b1, 1'b0, r[0], 1'b1, v, "rand_pause");
      else              drive(1'b1, 1'b0, 1'b0, 1'b0, v, "rand_idle");
    end

    @(negedge clk);
    load = 1'b0; start = 1'b0; pause = 1'b0;
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d pending entries want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_countdown_mmss.md
Name: bcd_countdown_mmss

Overview:
- Loadable BCD minutes:seconds down-counter (00:00 to 59:59). It is the decrementing counterpart of the team's mod-60 BCD up-counter.
- Used for kitchen/lap countdown timers. Digit outputs feed the same 7-segment path as the up-counter.
- A single-cycle done pulse and an expired level are provided for the alarm logic.

Parameters:
- TICK_DIV, default 50000000: clk cycles per one-second decrement. Legal range ≥1. Prescaler width is ceil(log2(TICK_DIV)), minimum 1.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- load  in  1  load request; sampled each rising edge
- ld_min_hi  in  4  load value, minutes tens (BCD, 0-5)
- ld_min_lo  in  4  load value, minutes units (BCD, 0-9)
- ld_sec_hi  in  4  load value, seconds tens (BCD, 0-5)
- ld_sec_lo  in  4  load value, seconds units (BCD, 0-9)
- start  in  1  start/resume request
- pause  in  1  pause request
- min_hi  out  4  current minutes tens
- min_lo  out  4  current minutes units
- sec_hi  out  4  current seconds tens
- sec_lo  out  4  current seconds units
- running  out  1  high while state is RUN
- done  out  1  one-cycle pulse on reaching 00:00
- expired  out  1  high while state is EXPIRED
- load_err  out  1  one-cycle pulse when a load is rejected

Behaviour:
- Reset (reset=0, asynchronous):
  - All digits 0; prescaler 0; state IDLE.
  - running=0, done=0, expired=0, load_err=0.
  - Reset mid-RUN aborts immediately; there is no resume.
- States: IDLE, RUN, PAUSED, EXPIRED. All outputs are registered.
- load:
  - Accepted in IDLE, PAUSED and EXPIRED; ignored in RUN (no load_err).
  - Valid load: all four digits update next cycle; prescaler cleared; state becomes IDLE; expired clears.
  - Invalid load: any units digit >9, or any tens digit >5. Digits are unchanged, state is unchanged, and load_err pulses for 1 cycle.
- start:
  - In IDLE or PAUSED with value ≠ 00:00: enter RUN.
  - From IDLE the prescaler is cleared. From PAUSED the prescaler is held, so the partial second is kept.
  - start with value 00:00 is ignored. start in RUN or EXPIRED is ignored.
- pause: in RUN, enter PAUSED next cycle; prescaler and digits are frozen. Ignored in other states.
- Priority within one cycle: load > pause > start.
  - load+start: only the load takes effect.
  - pause+start in RUN: pause wins.
- Prescaler (RUN only):
  - Increments each cycle, 0..TICK_DIV-1.
  - At TICK_DIV-1 it wraps to 0 and issues a tick.
  - First decrement occurs TICK_DIV cycles after entering RUN from IDLE.
- Decrement on tick (ripple borrow):
  - sec_lo: 0 becomes 9 with borrow, else -1.
  - sec_hi (on borrow): 0 becomes 5 with borrow, else -1.
  - min_lo (on borrow): 0 becomes 9 with borrow, else -1.
  - min_hi (on borrow): -1. Never underflows, because RUN requires a nonzero value.
- Terminal: when a tick produces 00:00:
  - Same edge: digits become 00:00, state becomes EXPIRED, done=1 for exactly that cycle.
  - expired=1 from that cycle until a valid load or reset.
- Digits always hold legal BCD; outputs never show intermediate borrow values.

Optional Feature:
- Macro: BCD_COUNTDOWN_AUTO_RELOAD_EN.
- Defined:
  - Each accepted load is also captured into a 16-bit reload register (reset value 0).
  - On reaching 00:00, the block reloads the captured value and stays in RUN; done still pulses 1 cycle; expired never asserts.
  - If the captured value is 00:00, the block enters EXPIRED as normal.
- Undefined: no reload register; terminal behaviour is exactly as described under Behaviour.

Test Plan:
1. Sim config TICK_DIV=4; reset low 2 cycles → all digits 0, state IDLE, running=0, done=0, expired=0, load_err=0.
2. Load 01:00, then start → running=1. After 4 cycles: 00:59. After 4 more: 00:58.
3. Load 00:02, start → 00:01 at cycle 4, 00:00 at cycle 8. done=1 for that cycle only; expired=1 held. A further start leaves 00:00 and EXPIRED unchanged.
4. Load 10:00, start, pause 2 cycles into RUN → frozen 10:00, running=0. start → 09:59 exactly 2 cycles later (partial second kept). Check min_lo borrow 0→9 and min_hi decrement.
5. Load 06:70 (sec_hi=7) → load_err pulse 1 cycle; digits unchanged. Load 03:00 during RUN → ignored, load_err=0. load+start in same cycle in IDLE → value loaded, running stays 0.
6. With BCD_COUNTDOWN_AUTO_RELOAD_EN: load 00:01, start → done pulses at cycle 4 and digits return to 00:01 with running=1. Second done at cycle 8; expired stays 0. Assert reset mid-RUN → immediate zero state and IDLE.
